// File: rtl/clk_div_prog.sv
`default_nettype none
// clk_div_prog: programmable integer clock divider; divisor changes only at period boundaries.
// Optional macro CLK_DIV_PROG_ODD_DUTY50_EN adds a negedge flop for 50% duty on odd divisors.
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             cfg_err
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             run_q, run_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;

    logic [CNT_W:0]   half;
    logic             wrap;
    logic             load_ok;
    logic             boundary;

    always_comb begin
        // One extra bit keeps (N+1) from overflowing at the maximum divisor.
        half     = ({1'b0, div_q} + (CNT_W+1)'(1)) >> 1;
        wrap     = (cnt_q == (div_q - CNT_W'(1)));
        load_ok  = div_load && (div_val >= CNT_W'(2));
        boundary = !run_q || wrap;

        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        run_d      = run_q;
        clk_out_d  = 1'b0;
        tick_d     = 1'b0;
        cfg_err_d  = div_load && !load_ok;

        if (run_q) begin
            clk_out_d = ({1'b0, cnt_q} < half);
            tick_d    = (cnt_q == '0);
            if (wrap) begin
                cnt_d = '0;
                run_d = en;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
            run_d = en;
        end

        if (load_ok) begin
            pend_d     = div_val;
            pend_vld_d = 1'b1;
        end

        // A load coinciding with the boundary takes effect immediately.
        if (boundary) begin
            if (load_ok) begin
                div_d      = div_val;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                div_d      = pend_q;
                pend_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= CNT_W'(DIV_DEFAULT);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            run_q      <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            run_q      <= run_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

`ifdef CLK_DIV_PROG_ODD_DUTY50_EN
    logic neg_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= clk_out_q;
        end
    end

    // Delaying the rise by half a cycle trims odd divisors to exactly N/2 high.
    assign clk_out = div_q[0] ? (clk_out_q & neg_q) : clk_out_q;
`else
    assign clk_out = clk_out_q;
`endif

    assign tick    = tick_q;
    assign busy    = run_q;
    assign cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// tb_clk_div_prog: stimulus predicts whole output periods into a scoreboard;
// an independent monitor measures each period between ticks and compares.
module tb_clk_div_prog;

    localparam int CNT_W       = 8;
    localparam int DIV_DEFAULT = 8;
    localparam int NMAX        = (1 << CNT_W) - 1;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             en       = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_val  = '0;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic             cfg_err;

    typedef struct {
        int n;
        bit stop;
    } period_t;

    period_t exp_q[$];
    int      err_edges[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      edge_cnt = 0;
    int      cur_n    = DIV_DEFAULT;

    bit      p_in  = 1'b0;
    period_t p_cur;
    int      p_len = 0;
    bit      p_ok  = 1'b1;

    clk_div_prog #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic close_period(input bit by_stop);
        n_checks++;
        if (!(p_len == p_cur.n && p_ok && by_stop == p_cur.stop)) begin
            n_fail++;
            $display("FAIL period: len %0d shape_ok %0d ended_by_stop %0d, expected len %0d high %0d ended_by_stop %0d (t=%0t)",
                     p_len, p_ok, by_stop, p_cur.n, (p_cur.n + 1) / 2, p_cur.stop, $time);
        end
        p_in = 1'b0;
    endtask

    // Monitor: one period runs from a tick sample to the next tick, or through the sample where busy falls.
    initial begin : monitor
        bit exp_err;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_in = 1'b0;
                continue;
            end
            exp_err = (err_edges.size() > 0) && (err_edges[0] == edge_cnt);
            if (exp_err) void'(err_edges.pop_front());
            if (exp_err || cfg_err !== 1'b0) check("cfg_err", cfg_err, exp_err);

            if (tick === 1'b1) begin
                if (p_in) close_period(1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", 1, 0);
                end else begin
                    p_cur = exp_q.pop_front();
                    p_in  = 1'b1;
                    p_len = 0;
                    p_ok  = 1'b1;
                end
            end

            if (p_in) begin
                if (clk_out !== ((p_len < (p_cur.n + 1) / 2) ? 1'b1 : 1'b0)) p_ok = 1'b0;
                p_len++;
                if (busy !== 1'b1) close_period(1'b1);
                else if (p_len > NMAX + 4) close_period(1'b0);
            end else if (tick !== 1'b1) begin
                check("idle_clk_out", clk_out, 0);
            end
        end
    end

    task automatic step(input bit e, input bit ld, input int v);
        en       = e;
        div_load = ld;
        div_val  = v[CNT_W-1:0];
        if (ld && v < 2) err_edges.push_back(edge_cnt + 1);
        @(posedge clk);
        #1;
        div_load = 1'b0;
    endtask

    function automatic int rand_n();
        int r;
        r = int'($urandom_range(0, 39));
        if (r == 0) return NMAX;
        if (r < 4) return 2;
        if (r < 7) return 3;
        return int'($urandom_range(2, 12));
    endfunction

    function automatic int rand_load();
        if ($urandom_range(0, 4) == 0) return int'($urandom_range(0, 1));
        return rand_n();
    endfunction

    // Runs `periods` periods from idle; fl*/fv* force loads at given offsets of the first period.
    task automatic scenario(input int periods, input bit rnd,
                            input int fl1, input int fv1, input int fl2, input int fv2);
        int v;
        int n;
        int nxt;
        int l1;
        int l2;
        int v1;
        int v2;
        int d0;
        int d1;
        bit last;
        bit ld;
        if (rnd && $urandom_range(0, 1) == 1) begin
            v = rand_load();
            step(1'b0, 1'b1, v);
            if (v >= 2) cur_n = v;
        end
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        check("start_busy", busy, 1);
        check("start_clk_out_low", clk_out, 0);
        for (int j = 0; j < periods; j++) begin
            last = (j == periods - 1);
            n    = cur_n;
            nxt  = cur_n;
            l1 = -1; l2 = -1; v1 = 0; v2 = 0;
            if (rnd && $urandom_range(0, 1) == 1) begin
                l1 = int'($urandom_range(0, n - 1));
                v1 = rand_load();
                if (l1 < n - 1 && $urandom_range(0, 1) == 1) begin
                    l2 = int'($urandom_range(l1 + 1, n - 1));
                    v2 = rand_load();
                end
            end
            if (j == 0 && fl1 >= 0) begin l1 = fl1; v1 = fv1; end
            if (j == 0 && fl2 >= 0) begin l2 = fl2; v2 = fv2; end
            if (last) begin
                d0 = rnd ? int'($urandom_range(0, n - 1)) : n - 1;
                d1 = n;
            end else if (rnd && $urandom_range(0, 2) == 0) begin
                d0 = int'($urandom_range(0, n - 2));
                d1 = int'($urandom_range(d0 + 1, n - 1));
            end else begin
                d0 = n;
                d1 = n;
            end
            exp_q.push_back('{n, last});
            for (int c = 0; c < n; c++) begin
                ld = 1'b0;
                v  = 0;
                if (c == l1) begin ld = 1'b1; v = v1; end
                if (c == l2) begin ld = 1'b1; v = v2; end
                if (ld && v >= 2) nxt = v;
                step(!(c >= d0 && c < d1), ld, v);
                if (j == 0 && c == 0) begin
                    check("first_tick", tick, 1);
                    check("first_clk_out_high", clk_out, 1);
                end
            end
            cur_n = nxt;
        end
        repeat (int'($urandom_range(1, 4))) step(1'b0, 1'b0, 0);
    endtask

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;

        scenario(3, 1'b0, -1, 0, -1, 0);
        step(1'b0, 1'b1, 5);
        cur_n = 5;
        scenario(2, 1'b0, -1, 0, -1, 0);
        step(1'b0, 1'b1, 8);
        cur_n = 8;
        scenario(3, 1'b0, 2, 4, 5, 6);
        step(1'b0, 1'b1, 1);
        step(1'b0, 1'b1, 0);
        scenario(1, 1'b0, -1, 0, -1, 0);
        step(1'b0, 1'b1, NMAX);
        cur_n = NMAX;
        scenario(1, 1'b0, -1, 0, -1, 0);

        for (int k = 0; k < 30; k++) scenario(int'($urandom_range(1, 4)), 1'b1, -1, 0, -1, 0);

        // Reset during the first high cycle, with a pending load outstanding.
        step(1'b0, 1'b1, 10);
        cur_n = 10;
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        exp_q.push_back('{10, 1'b0});
        step(1'b1, 1'b1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clk_out", clk_out, 0);
        check("async_rst_tick", tick, 0);
        check("async_rst_busy", busy, 0);
        exp_q.delete();
        err_edges.delete();
        en    = 1'b0;
        cur_n = DIV_DEFAULT;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        scenario(2, 1'b0, -1, 0, -1, 0);

        repeat (5) step(1'b0, 1'b0, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        check("no_open_period", p_in, 0);
        check("cfg_err_drained", err_edges.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
